// File: rtl/controller_pio_pulse_out.sv
// Avalon-MM parallel output port with per-bit pulse mode: masked bits that rise on a
// data write stay high for max(plen,1) cycles, then clear and raise the done flag.
module controller_pio_pulse_out #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_PMASK  = 3'd1;
  localparam logic [2:0] A_PLEN   = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_SET    = 3'd4;
  localparam logic [2:0] A_CLEAR  = 3'd5;
  localparam logic [2:0] A_TOGGLE = 3'd6;
  localparam logic [2:0] A_CTRL   = 3'd7;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_pmask;
  logic [CNT_W-1:0] r_plen;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic             r_irq_en;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_data_wr;
  logic             w_data_addr;
  logic             w_trig;
  logic             w_expire;
  logic             w_busy;
  logic [CNT_W-1:0] w_load;

  assign w_wr        = chipselect & ~write_n;
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_data_addr = (address == A_DATA) || (address == A_SET) || (address == A_TOGGLE);
  assign w_busy      = (r_count != '0);
  assign w_load      = (r_plen == '0) ? CNT_W'(1) : r_plen;

  // Data value after this cycle's write, before any expiry clear is applied
  always_comb begin
    w_data_wr = r_data_out;
    if (w_wr) begin
      case (address)
        A_DATA:   w_data_wr = w_wd;
        A_SET:    w_data_wr = r_data_out | w_wd;
        A_CLEAR:  w_data_wr = r_data_out & ~w_wd;
        A_TOGGLE: w_data_wr = r_data_out ^ w_wd;
        default:  w_data_wr = r_data_out;
      endcase
    end
  end

  // A rising masked bit (CLEAR can never raise one) retriggers; trigger beats expiry
  assign w_trig   = w_wr && w_data_addr && (|(~r_data_out & w_data_wr & r_pmask));
  assign w_expire = (r_count == CNT_W'(1)) && !w_trig;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= '0;
      r_pmask    <= '0;
      r_plen     <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_irq_en   <= 1'b0;
    end else begin
      r_data_out <= w_expire ? (w_data_wr & ~r_pmask) : w_data_wr;

      if (w_trig)
        r_count <= w_load;
      else if (w_busy)
        r_count <= r_count - CNT_W'(1);

      if (w_wr && (address == A_PMASK))
        r_pmask <= w_wd;
      if (w_wr && (address == A_PLEN))
        r_plen <= writedata[CNT_W-1:0];
      if (w_wr && (address == A_CTRL))
        r_irq_en <= writedata[0];

      if (w_expire)
        r_done <= 1'b1;
      else if (w_wr && (address == A_STATUS) && writedata[0])
        r_done <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:   readdata = 32'(r_data_out);
      A_PMASK:  readdata = 32'(r_pmask);
      A_PLEN:   readdata = 32'(r_plen);
      A_STATUS: readdata = {30'd0, w_busy, r_done};
      A_CTRL:   readdata = {31'd0, r_irq_en};
      default:  readdata = '0;
    endcase
  end

  assign out_port = r_data_out;
  assign irq      = r_done & r_irq_en;

endmodule

// File: doc/controller_pio_pulse_out.md
CONTROLLER_PIO_PULSE_OUT -- requirements
Module: controller_pio_pulse_out

Interface
REQ-001 The block SHALL accept parameter: WIDTH, default 8, output port width (legal 1..32).
REQ-002 The block SHALL accept parameter: CNT_W, default 16, pulse-length counter width (legal 1..31).
REQ-003 The block SHALL have port: clk  input  1  single clock; all logic on posedge clk.
REQ-004 The block SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port: address  input  3  Avalon word address.
REQ-006 The block SHALL have port: chipselect  input  1  slave select.
REQ-007 The block SHALL have port: write_n  input  1  active-low write strobe.
REQ-008 The block SHALL have port: writedata  input  32  write data.
REQ-009 The block SHALL have port: readdata  output  32  read data, zero-extended, combinational from address (zero read latency).
REQ-010 The block SHALL have port: out_port  output  WIDTH  registered output pins (= data_out).
REQ-011 The block SHALL have port: irq  output  1  level interrupt = done & irq_en.

Function
REQ-012 The block SHALL qualify every write as wr = chipselect & ~write_n; there SHALL be no wait states or read side effects.
REQ-013 The block SHALL provide a register map (address: name, write behaviour, read value):
- 0: DATA, data_out <= wd[WIDTH-1:0], reads data_out.
- 1: PMASK, pmask <= wd[WIDTH-1:0], reads pmask.
- 2: PLEN, plen <= wd[CNT_W-1:0], reads plen.
- 3: STATUS, writing 1 to bit0 clears done, reads {busy, done} at bits [1:0].
- 4: SET, data_out |= wd, reads 0.
- 5: CLEAR, data_out &= ~wd, reads 0.
- 6: TOGGLE, data_out ^= wd, reads 0.
- 7: CTRL, irq_en <= wd[0], reads irq_en.
REQ-014 The block SHALL ignore bits of writedata above the relevant register width and SHALL read those bits as 0.
REQ-015 The block SHALL define a pulse trigger as any cycle where a write to address 0, 4 or 6 produces a 0->1 transition on any data_out bit whose pmask bit is 1.
REQ-016 On a trigger, the block SHALL load count <= (plen == 0) ? 1 : plen, whether or not count is already nonzero (retrigger restarts the window).
REQ-017 While count != 0 and no trigger occurs, the block SHALL decrement count by 1 per clk.
REQ-018 The block SHALL drive busy = (count != 0).
REQ-019 In the cycle count == 1 and no trigger occurs, the block SHALL clear every data_out bit with pmask = 1, set count <= 0 and set done <= 1.
REQ-020 A pulse-mode bit SHALL stay high for exactly max(plen,1) cycles after the write edge.
REQ-021 Non-pmask bits SHALL never be altered by expiry.
REQ-022 On simultaneous expiry and a trigger, the trigger SHALL win: the block SHALL apply the write, reload count, leave pmask bits set by the write high, and leave done unchanged.
REQ-023 On simultaneous expiry and a non-trigger write to address 0/4/5/6, the block SHALL apply the expiry clear after the write, so that pmask bits end 0.
REQ-024 On a STATUS bit0 write coinciding with expiry, the block SHALL set done (set wins).
REQ-025 Changes to pmask or plen while busy SHALL NOT alter the current count; expiry SHALL use the pmask value present in the expiry cycle.
REQ-026 Writes to addresses 1, 2, 3 and 7 SHALL never trigger.
REQ-027 Clearing pmask bits while busy SHALL leave those bits latched.

Reset
REQ-028 When reset is 1 at a posedge clk, the block SHALL set data_out, pmask, plen, count, done and irq_en to 0.
REQ-029 During reset, out_port and irq SHALL be 0 and readdata SHALL follow the reset register values.
REQ-030 A reset asserted mid-pulse SHALL abort the pulse with no done set.
REQ-031 Reset SHALL take priority over any coincident write.

Verification
REQ-032 The bench SHALL cover: reset, then write DATA=0xA5 -> out_port=0xA5 next cycle; SET 0x0F -> 0xAF; CLEAR 0x81 -> 0x2E; TOGGLE 0xFF -> 0xD1; reads of addresses 4..6 = 0.
REQ-033 The bench SHALL cover: PMASK=0x01, PLEN=4, SET 0x01 -> out_port[0] high exactly 4 cycles then 0, busy high for 4 cycles, done=1; with CTRL=1, irq=1 until STATUS write 0x1.
REQ-034 The bench SHALL cover: PLEN=0, pulse bit set -> high exactly 1 cycle, done=1.
REQ-035 The bench SHALL cover: PLEN=5, set bit0, re-SET bit0 after clearing it at cycle 3 -> pulse extends to 5 cycles after the second write; done set once at final expiry.
REQ-036 The bench SHALL cover: simultaneous expiry and TOGGLE re-raising a pmask bit -> bit stays high, count reloads, done unchanged; simultaneous expiry and STATUS clear -> done=1.
REQ-037 The bench SHALL cover: reset asserted at cycle 2 of a PLEN=10 pulse -> next cycle out_port=0, busy=0, done=0, irq=0.
